rt_ibex_window_ctrl: RTL and testbench

Sequencer that drives the windowed register file's pointer and CSR-save controls on interrupt entry and `mret`. It sits between the core controller and the register window. It tracks hardware nesting depth and counts software-stacked nesting levels once all hardware windows are in use. On return it restores `mcause`/`mepc` from the auxiliary store to the CSR file.

---
 rtl/rt_ibex_window_pkg.sv | 22 ++
 rtl/rt_ibex_sat_counter.sv | 30 +++
 rtl/rt_ibex_window_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rt_ibex_window_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_ibex_window_pkg.sv
// Shared types and width helpers for the register-window sequencer.
package rt_ibex_window_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INC,
        SAVE,
        OVF_ACK,
        DEC,
        RESTORE
    } window_ctrl_state_e;

    // A single hardware window still needs a one-bit depth field.
    function automatic int depth_width(input int num_windows);
        return (num_windows > 1) ? $clog2(num_windows) : 1;
    endfunction

    function automatic int ovf_width(input int ovf_depth);
        return (ovf_depth > 0) ? $clog2(ovf_depth + 1) : 1;
    endfunction

endpackage

// File: rtl/rt_ibex_sat_counter.sv
// Up/down counter that sticks at zero and at Max instead of wrapping.
module rt_ibex_sat_counter #(
    parameter int               Width = 4,
    parameter logic [Width-1:0] Max   = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o
);

    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] cnt_q;

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i && (cnt_q != Max)) begin
            cnt_q <= cnt_q + One;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - One;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rt_ibex_window_ctrl.sv
// Interrupt entry / mret sequencer for the windowed register file.
// Optional overflow statistics counter: define RT_IBEX_WINDOW_STATS_EN.
module rt_ibex_window_ctrl
    import rt_ibex_window_pkg::*;
#(
    parameter int NumRegisterWindows = 4,
    parameter int OvfDepth           = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       irq_enter_req_i,
    output logic                                       irq_enter_ack_o,
    output logic                                       irq_enter_hw_o,
    input  logic                                       mret_req_i,
    output logic                                       mret_ack_o,
    output logic                                       mret_hw_o,
    input  logic                                       window_full_i,
    output logic                                       increment_ptr_o,
    output logic                                       decrement_ptr_o,
    output logic                                       save_csr_o,
    input  logic [31:0]                                mcause_rf_i,
    input  logic [31:0]                                mepc_rf_i,
    output logic                                       csr_restore_o,
    output logic [31:0]                                mcause_restore_o,
    output logic [31:0]                                mepc_restore_o,
    output logic [depth_width(NumRegisterWindows)-1:0] depth_o,
    output logic [ovf_width(OvfDepth)-1:0]             ovf_cnt_o,
    output logic                                       err_o,
    output logic [31:0]                                stat_ovf_total_o
);

    localparam int               DepthW   = depth_width(NumRegisterWindows);
    localparam int               OvfW     = ovf_width(OvfDepth);
    localparam logic [DepthW-1:0] DepthMax = DepthW'(NumRegisterWindows - 1);
    localparam logic [DepthW-1:0] DepthOne = DepthW'(1);
    localparam logic [OvfW-1:0]   OvfMax   = OvfW'(OvfDepth);

    window_ctrl_state_e state_q, state_d;
    logic               is_entry_q, is_entry_d;
    logic [DepthW-1:0]  depth_q;
    logic [OvfW-1:0]    ovf_cnt;
    logic               ovf_inc, ovf_dec, err_set, err_q;
    logic               restore_now;
    logic [31:0]        mcause_q, mepc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            is_entry_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_entry_q <= is_entry_d;
            err_q      <= err_q | err_set;
        end
    end

    // Entry wins arbitration; software-stacked levels unwind before hardware windows.
    always_comb begin
        state_d    = state_q;
        is_entry_d = is_entry_q;
        ovf_inc    = 1'b0;
        ovf_dec    = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (irq_enter_req_i) begin
                    is_entry_d = 1'b1;
                    if (window_full_i) begin
                        state_d = OVF_ACK;
                        ovf_inc = 1'b1;
                        err_set = (ovf_cnt == OvfMax);
                    end else begin
                        state_d = INC;
                    end
                end else if (mret_req_i) begin
                    is_entry_d = 1'b0;
                    if (ovf_cnt != '0) begin
                        state_d = OVF_ACK;
                        ovf_dec = 1'b1;
                    end else if (depth_q != '0) begin
                        state_d = DEC;
                    end else begin
                        state_d = OVF_ACK;
                        err_set = 1'b1;
                    end
                end
            end
            INC:     state_d = SAVE;
            DEC:     state_d = RESTORE;
            SAVE,
            OVF_ACK,
            RESTORE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q <= '0;
        end else if ((state_q == INC) && (depth_q != DepthMax)) begin
            depth_q <= depth_q + DepthOne;
        end else if ((state_q == DEC) && (depth_q != '0)) begin
            depth_q <= depth_q - DepthOne;
        end
    end

    rt_ibex_sat_counter #(
        .Width (OvfW),
        .Max   (OvfMax)
    ) u_ovf_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ovf_inc),
        .dec_i  (ovf_dec),
        .cnt_o  (ovf_cnt)
    );

`ifdef RT_IBEX_WINDOW_STATS_EN
    rt_ibex_sat_counter #(
        .Width (32)
    ) u_stat_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ovf_inc),
        .dec_i  (1'b0),
        .cnt_o  (stat_ovf_total_o)
    );
`else
    assign stat_ovf_total_o = '0;
`endif

    // Returning to depth 0 lands in the base window, which has no saved context.
    assign restore_now = (state_q == RESTORE) && (depth_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mcause_q <= '0;
            mepc_q   <= '0;
        end else if (restore_now) begin
            mcause_q <= mcause_rf_i;
            mepc_q   <= mepc_rf_i;
        end
    end

    // The aux store is read for the new pointer in the same cycle the restore is issued.
    assign mcause_restore_o = restore_now ? mcause_rf_i : mcause_q;
    assign mepc_restore_o   = restore_now ? mepc_rf_i   : mepc_q;
    assign csr_restore_o    = restore_now;

    assign increment_ptr_o  = (state_q == INC);
    assign save_csr_o       = (state_q == SAVE);
    assign decrement_ptr_o  = (state_q == DEC);
    assign irq_enter_ack_o  = (state_q == SAVE) || ((state_q == OVF_ACK) && is_entry_q);
    assign irq_enter_hw_o   = (state_q == SAVE);
    assign mret_ack_o       = (state_q == RESTORE) || ((state_q == OVF_ACK) && !is_entry_q);
    assign mret_hw_o        = (state_q == RESTORE);
    assign depth_o          = depth_q;
    assign ovf_cnt_o        = ovf_cnt;
    assign err_o            = err_q;

endmodule

// File: tb/tb_rt_ibex_window_ctrl.sv
// Self-checking bench for rt_ibex_window_ctrl: directed table, corner sequences, random vs. model.
module tb_rt_ibex_window_ctrl;
    import rt_ibex_window_pkg::*;

    localparam int NW = 4;
    localparam int OD = 8;
    localparam int DW = depth_width(NW);
    localparam int OW = ovf_width(OD);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          irq_enter_req_i = 1'b0;
    logic          irq_enter_ack_o, irq_enter_hw_o;
    logic          mret_req_i = 1'b0;
    logic          mret_ack_o, mret_hw_o;
    logic          window_full_i = 1'b0;
    logic          increment_ptr_o, decrement_ptr_o, save_csr_o;
    logic [31:0]   mcause_rf_i = '0;
    logic [31:0]   mepc_rf_i = '0;
    logic          csr_restore_o;
    logic [31:0]   mcause_restore_o, mepc_restore_o;
    logic [DW-1:0] depth_o;
    logic [OW-1:0] ovf_cnt_o;
    logic          err_o;
    logic [31:0]   stat_ovf_total_o;

    rt_ibex_window_ctrl #(
        .NumRegisterWindows (NW),
        .OvfDepth           (OD)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .irq_enter_req_i  (irq_enter_req_i),
        .irq_enter_ack_o  (irq_enter_ack_o),
        .irq_enter_hw_o   (irq_enter_hw_o),
        .mret_req_i       (mret_req_i),
        .mret_ack_o       (mret_ack_o),
        .mret_hw_o        (mret_hw_o),
        .window_full_i    (window_full_i),
        .increment_ptr_o  (increment_ptr_o),
        .decrement_ptr_o  (decrement_ptr_o),
        .save_csr_o       (save_csr_o),
        .mcause_rf_i      (mcause_rf_i),
        .mepc_rf_i        (mepc_rf_i),
        .csr_restore_o    (csr_restore_o),
        .mcause_restore_o (mcause_restore_o),
        .mepc_restore_o   (mepc_restore_o),
        .depth_o          (depth_o),
        .ovf_cnt_o        (ovf_cnt_o),
        .err_o            (err_o),
        .stat_ovf_total_o (stat_ovf_total_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          lat;
        bit          enter;
        bit          hw;
        int          inc_n;
        int          dec_n;
        int          save_n;
        int          restore_n;
        int          hw_glitch;
        logic [31:0] mc;
        logic [31:0] me;
    } obs_t;

    typedef struct {
        int lat;
        bit enter;
        bit hw;
        bit restore;
        int depth;
        int ovf;
        bit err;
    } exp_t;

    typedef struct {
        bit          ent;
        bit          mr;
        bit          full;
        logic [31:0] mc;
        logic [31:0] me;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference state.
    int          m_depth, m_ovf, m_stat;
    bit          m_err;
    logic [31:0] m_mc, m_me;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_depth = 0; m_ovf = 0; m_stat = 0; m_err = 1'b0; m_mc = '0; m_me = '0;
    endtask

    task automatic predict(input bit ent, input bit full, input logic [31:0] mc,
                           input logic [31:0] me, output exp_t e);
        e = '{default: 0};
        e.enter = ent;
        if (ent && full) begin
            e.lat = 1;
            if (m_ovf == OD) m_err = 1'b1;
            else m_ovf++;
            m_stat++;
        end else if (ent) begin
            e.lat = 2; e.hw = 1'b1;
            m_depth++;
        end else if (m_ovf > 0) begin
            e.lat = 1;
            m_ovf--;
        end else if (m_depth > 0) begin
            e.lat = 2; e.hw = 1'b1;
            m_depth--;
            if (m_depth > 0) begin
                e.restore = 1'b1; m_mc = mc; m_me = me;
            end
        end else begin
            e.lat = 1;
            m_err = 1'b1;
        end
        e.depth = m_depth; e.ovf = m_ovf; e.err = m_err;
    endtask

    // Starts in an IDLE cycle, ends one cycle after the ack (back in IDLE).
    task automatic applyStimulus(input bit ent, input bit mr, input bit full,
                                 input logic [31:0] mc, input logic [31:0] me, output obs_t o);
        o = '{default: 0};
        o.lat = -1;
        if (ent) irq_enter_req_i = 1'b1;
        if (mr) mret_req_i = 1'b1;
        window_full_i = full;
        mcause_rf_i = mc;
        mepc_rf_i = me;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_i); #1;
            o.inc_n  += int'(increment_ptr_o);
            o.dec_n  += int'(decrement_ptr_o);
            o.save_n += int'(save_csr_o);
            if ((!irq_enter_ack_o && irq_enter_hw_o) || (!mret_ack_o && mret_hw_o)) o.hw_glitch++;
            if (csr_restore_o) begin
                o.restore_n++; o.mc = mcause_restore_o; o.me = mepc_restore_o;
            end
            if (irq_enter_ack_o || mret_ack_o) begin
                o.lat = i;
                o.enter = irq_enter_ack_o;
                o.hw = irq_enter_ack_o ? irq_enter_hw_o : mret_hw_o;
                break;
            end
        end
        if (o.lat < 0) begin
            irq_enter_req_i = 1'b0; mret_req_i = 1'b0;
        end else if (o.enter) begin
            irq_enter_req_i = 1'b0;
        end else begin
            mret_req_i = 1'b0;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic compare_txn(input string tag, input obs_t o, input exp_t e,
                               input logic [31:0] mc, input logic [31:0] me);
        logic [31:0] stat_req;
`ifdef RT_IBEX_WINDOW_STATS_EN
        stat_req = 32'(m_stat);
`else
        stat_req = '0;
`endif
        checkOutput({tag, " latency"}, 32'(o.lat), 32'(e.lat));
        checkOutput({tag, " ack_kind"}, 32'(o.enter), 32'(e.enter));
        checkOutput({tag, " hw"}, 32'(o.hw), 32'(e.hw));
        checkOutput({tag, " hw_without_ack"}, 32'(o.hw_glitch), 0);
        checkOutput({tag, " inc_pulses"}, 32'(o.inc_n), (e.enter && e.hw) ? 1 : 0);
        checkOutput({tag, " save_pulses"}, 32'(o.save_n), (e.enter && e.hw) ? 1 : 0);
        checkOutput({tag, " dec_pulses"}, 32'(o.dec_n), (!e.enter && e.hw) ? 1 : 0);
        checkOutput({tag, " restore_pulses"}, 32'(o.restore_n), 32'(e.restore));
        if (e.restore) begin
            checkOutput({tag, " mcause_restore"}, o.mc, mc);
            checkOutput({tag, " mepc_restore"}, o.me, me);
        end
        checkOutput({tag, " depth"}, 32'(depth_o), 32'(e.depth));
        checkOutput({tag, " ovf_cnt"}, 32'(ovf_cnt_o), 32'(e.ovf));
        checkOutput({tag, " err"}, 32'(err_o), 32'(e.err));
        checkOutput({tag, " stat"}, stat_ovf_total_o, stat_req);
        checkOutput({tag, " mcause_hold"}, mcause_restore_o, m_mc);
        checkOutput({tag, " mepc_hold"}, mepc_restore_o, m_me);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, " ctrl"}, {22'b0, irq_enter_ack_o, irq_enter_hw_o, mret_ack_o, mret_hw_o,
                    increment_ptr_o, decrement_ptr_o, save_csr_o, csr_restore_o, err_o, 1'b0}, 0);
        checkOutput({tag, " depth"}, 32'(depth_o), 0);
        checkOutput({tag, " ovf_cnt"}, 32'(ovf_cnt_o), 0);
        checkOutput({tag, " mcause"}, mcause_restore_o, 0);
        checkOutput({tag, " mepc"}, mepc_restore_o, 0);
        checkOutput({tag, " stat"}, stat_ovf_total_o, 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        irq_enter_req_i = 1'b0; mret_req_i = 1'b0; window_full_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic run_model_txn(input string tag, input bit ent, input bit full,
                                 input logic [31:0] mc, input logic [31:0] me);
        obs_t o;
        exp_t e;
        applyStimulus(ent, !ent, full, mc, me, o);
        predict(ent, full, mc, me, e);
        compare_txn(tag, o, e, mc, me);
    endtask

    vec_t vecs[11];

    initial begin
        obs_t o;
        exp_t e;

        // ent mr full mcause mepc | lat enter hw restore depth ovf err
        vecs[0]  = '{1, 0, 0, 32'h0,         32'h0,     '{2, 1, 1, 0, 1, 0, 0}};
        vecs[1]  = '{0, 1, 0, 32'h0,         32'h0,     '{2, 0, 1, 0, 0, 0, 0}};
        vecs[2]  = '{1, 0, 0, 32'h0,         32'h0,     '{2, 1, 1, 0, 1, 0, 0}};
        vecs[3]  = '{1, 0, 0, 32'h0,         32'h0,     '{2, 1, 1, 0, 2, 0, 0}};
        vecs[4]  = '{1, 0, 0, 32'h0,         32'h0,     '{2, 1, 1, 0, 3, 0, 0}};
        vecs[5]  = '{0, 1, 0, 32'h8000_0007, 32'h100,   '{2, 0, 1, 1, 2, 0, 0}};
        vecs[6]  = '{1, 0, 1, 32'h0,         32'h0,     '{1, 1, 0, 0, 2, 1, 0}};
        vecs[7]  = '{0, 1, 0, 32'hDEAD_BEEF, 32'h4,     '{1, 0, 0, 0, 2, 0, 0}};
        vecs[8]  = '{0, 1, 0, 32'h8000_000B, 32'h200,   '{2, 0, 1, 1, 1, 0, 0}};
        vecs[9]  = '{0, 1, 0, 32'h1234_5678, 32'h300,   '{2, 0, 1, 0, 0, 0, 0}};
        vecs[10] = '{0, 1, 0, 32'h0,         32'h0,     '{1, 0, 0, 0, 0, 0, 1}};

        do_reset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ent, vecs[i].mr, vecs[i].full, vecs[i].mc, vecs[i].me, o);
            predict(vecs[i].ent, vecs[i].full, vecs[i].mc, vecs[i].me, e);
            compare_txn($sformatf("vec%0d", i), o, vecs[i].e, vecs[i].mc, vecs[i].me);
        end
        checkOutput("err_sticky", 32'(err_o), 1);

        // Overflow saturation: nine software-stacked entries, then unwind.
        do_reset();
        for (int i = 0; i < OD + 1; i++) begin
            run_model_txn($sformatf("ovf_entry%0d", i), 1'b1, 1'b1, 32'h0, 32'h0);
            checkOutput($sformatf("ovf_err_after%0d", i), 32'(err_o), (i == OD) ? 1 : 0);
        end
        checkOutput("ovf_saturated", 32'(ovf_cnt_o), OD);
        for (int i = 0; i < OD; i++) run_model_txn($sformatf("ovf_ret%0d", i), 1'b0, 1'b0, 32'h0, 32'h0);

        // Both requests in IDLE: entry first, then the still-pending mret.
        do_reset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, o);
        predict(1'b1, 1'b0, 32'h0, 32'h0, e);
        compare_txn("both_entry", o, e, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, o);
        predict(1'b0, 1'b0, 32'h0, 32'h0, e);
        compare_txn("both_mret", o, e, 32'h0, 32'h0);

        // Reset while the entry sits in SAVE.
        do_reset();
        run_model_txn("pre_abort", 1'b1, 1'b0, 32'h0, 32'h0);
        irq_enter_req_i = 1'b1;
        window_full_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        checkOutput("abort_in_save", 32'(save_csr_o), 1);
        rst_ni = 1'b0;
        #1;
        check_all_zero("abort");
        irq_enter_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        model_reset();

        // Random traffic; window_full_i follows the model like a real register window.
        for (int k = 0; k < 300; k++) begin
            bit ent;
            ent = ($urandom_range(0, 99) < 55);
            run_model_txn($sformatf("rnd%0d", k), ent, ent && (m_depth == NW - 1), $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
